// File: rtl/eth_pkg.sv
// Shared types for the Ethernet transmit packet FIFO.
// Beat layout and write-side state encoding.
package eth_pkg;

    localparam int ETH_DATA_WIDTH = 64;
    localparam int ETH_KEEP_WIDTH = ETH_DATA_WIDTH / 8;

    typedef struct packed {
        logic                      tlast;
        logic [ETH_KEEP_WIDTH-1:0] tkeep;
        logic [ETH_DATA_WIDTH-1:0] tdata;
    } eth_beat_t;

    typedef enum logic {
        WR_WRITE   = 1'b0,
        WR_DISCARD = 1'b1
    } wr_state_t;

endpackage

// File: rtl/eth_tx_pkt_ram.sv
// Simple dual-port beat store for the transmit FIFO.
// One write port, one registered read port that doubles as the output stage.
module eth_tx_pkt_ram #(
    parameter int AW = 9,
    parameter int W  = 73
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem [0:(1<<AW)-1];

    // Write port: array itself carries no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read register: holds its value until the next read enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/eth_tx_pkt_fifo.sv
// Store-and-forward transmit packet FIFO in front of the 10G MAC.
// Frames are released only after they are stored complete and good.
module eth_tx_pkt_fifo
    import eth_pkg::*;
#(
    parameter int DATA_WIDTH = ETH_DATA_WIDTH,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int DEPTH_LOG2 = 9
) (
    input  logic                  clk156,
    input  logic                  sys_rst156,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tuser,
    output logic                  m_axis_tx_tvalid,
    input  logic                  m_axis_tx_tready,
    output logic                  m_axis_tx_tlast,
    output logic [KEEP_WIDTH-1:0] m_axis_tx_tkeep,
    output logic [DATA_WIDTH-1:0] m_axis_tx_tdata,
    output logic                  m_axis_tx_tuser,
    output logic [31:0]           frame_tx_cnt,
    output logic [31:0]           frame_drop_cnt
);

    localparam int BW = 1 + KEEP_WIDTH + DATA_WIDTH;
    localparam logic [DEPTH_LOG2:0] DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] ONE = 1;

    logic [DEPTH_LOG2:0] wr_ptr;
    logic [DEPTH_LOG2:0] wr_commit;
    logic [DEPTH_LOG2:0] rd_ptr;

    wr_state_t st;
    wr_state_t st_n;

    logic acc;
    logic full;
    logic frame_avail;
    logic load;
    logic we;
    logic ptr_inc;
    logic commit;
    logic rollback;
    logic drop;

    logic [BW-1:0] rd_beat;

    // Upstream is never stalled; it only sees not-ready while in reset.
    assign s_axis_tready = ~sys_rst156;
    assign acc = s_axis_tvalid & s_axis_tready;

    // Full uses the registered read pointer, so a slot freed this cycle
    // is only counted next cycle.
    assign full = (wr_ptr - rd_ptr) == DEPTH;
    assign frame_avail = rd_ptr != wr_commit;
    assign load = frame_avail & (~m_axis_tx_tvalid | m_axis_tx_tready);

    assign m_axis_tx_tlast = rd_beat[BW-1];
    assign m_axis_tx_tkeep = rd_beat[BW-2 -: KEEP_WIDTH];
    assign m_axis_tx_tdata = rd_beat[DATA_WIDTH-1:0];
    assign m_axis_tx_tuser = 1'b0;

    // Write FSM state register.
    always_ff @(posedge clk156 or posedge sys_rst156) begin
        if (sys_rst156) begin
            st <= WR_WRITE;
        end else begin
            st <= st_n;
        end
    end

    // Write FSM next state: an overflow mid-frame discards the remainder.
    always_comb begin
        st_n = st;
        unique case (st)
            WR_WRITE: begin
                if (acc && full && !s_axis_tlast) begin
                    st_n = WR_DISCARD;
                end
            end
            WR_DISCARD: begin
                if (acc && s_axis_tlast) begin
                    st_n = WR_WRITE;
                end
            end
            default: st_n = WR_WRITE;
        endcase
    end

    // Write FSM outputs: store, advance, commit or roll back the frame.
    always_comb begin
        we       = 1'b0;
        ptr_inc  = 1'b0;
        commit   = 1'b0;
        rollback = 1'b0;
        drop     = 1'b0;
        unique case (st)
            WR_WRITE: begin
                if (acc && !full) begin
                    we = 1'b1;
                    if (s_axis_tlast && s_axis_tuser) begin
                        rollback = 1'b1;
                        drop     = 1'b1;
                    end else if (s_axis_tlast) begin
                        commit = 1'b1;
                    end else begin
                        ptr_inc = 1'b1;
                    end
                end else if (acc) begin
                    rollback = 1'b1;
                    drop     = s_axis_tlast;
                end
            end
            WR_DISCARD: begin
                drop = acc & s_axis_tlast;
            end
            default: begin
                drop = 1'b0;
            end
        endcase
    end

    // Pointer registers; rollback only ever moves the speculative pointer.
    always_ff @(posedge clk156 or posedge sys_rst156) begin
        if (sys_rst156) begin
            wr_ptr    <= '0;
            wr_commit <= '0;
            rd_ptr    <= '0;
        end else begin
            if (rollback) begin
                wr_ptr <= wr_commit;
            end else if (ptr_inc || commit) begin
                wr_ptr <= wr_ptr + ONE;
            end
            if (commit) begin
                wr_commit <= wr_ptr + ONE;
            end
            if (load) begin
                rd_ptr <= rd_ptr + ONE;
            end
        end
    end

    // Output valid: set on load, cleared after a handshake with no refill.
    always_ff @(posedge clk156 or posedge sys_rst156) begin
        if (sys_rst156) begin
            m_axis_tx_tvalid <= 1'b0;
        end else if (load) begin
            m_axis_tx_tvalid <= 1'b1;
        end else if (m_axis_tx_tready) begin
            m_axis_tx_tvalid <= 1'b0;
        end
    end

    // Frame statistics, both wrapping modulo 2^32.
    always_ff @(posedge clk156 or posedge sys_rst156) begin
        if (sys_rst156) begin
            frame_tx_cnt   <= '0;
            frame_drop_cnt <= '0;
        end else begin
            if (m_axis_tx_tvalid && m_axis_tx_tready && m_axis_tx_tlast) begin
                frame_tx_cnt <= frame_tx_cnt + 32'd1;
            end
            if (drop) begin
                frame_drop_cnt <= frame_drop_cnt + 32'd1;
            end
        end
    end

    eth_tx_pkt_ram #(
        .AW(DEPTH_LOG2),
        .W (BW)
    ) u_ram (
        .clk    (clk156),
        .rst    (sys_rst156),
        .wr_en  (we),
        .wr_addr(wr_ptr[DEPTH_LOG2-1:0]),
        .wr_data({s_axis_tlast, s_axis_tkeep, s_axis_tdata}),
        .rd_en  (load),
        .rd_addr(rd_ptr[DEPTH_LOG2-1:0]),
        .rd_data(rd_beat)
    );

endmodule

// File: tb/tb_eth_tx_pkt_fifo.sv
// Scoreboard bench for the transmit packet FIFO.
// Expected beats are queued at drive time and popped on m-side handshakes.
module tb_eth_tx_pkt_fifo;
    import eth_pkg::*;

    localparam int DL2 = 4;
    localparam int DEP = 1 << DL2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic        s_tlast = 1'b0;
    logic [7:0]  s_tkeep = 8'h00;
    logic [63:0] s_tdata = 64'h0;
    logic        s_tuser = 1'b0;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic        m_tlast;
    logic [7:0]  m_tkeep;
    logic [63:0] m_tdata;
    logic        m_tuser;
    logic [31:0] tx_cnt;
    logic [31:0] drop_cnt;

    int total = 0;
    int bad = 0;
    int mode = 0;
    int n_push = 0;
    int n_pop = 0;
    int exp_tx = 0;
    int exp_drop = 0;

    eth_beat_t exp_q[$];
    eth_beat_t prev;
    bit prev_stall = 0;
    bit in_frame = 0;

    eth_tx_pkt_fifo #(
        .DATA_WIDTH(64),
        .DEPTH_LOG2(DL2)
    ) dut (
        .clk156          (clk),
        .sys_rst156      (rst),
        .s_axis_tvalid   (s_tvalid),
        .s_axis_tready   (s_tready),
        .s_axis_tlast    (s_tlast),
        .s_axis_tkeep    (s_tkeep),
        .s_axis_tdata    (s_tdata),
        .s_axis_tuser    (s_tuser),
        .m_axis_tx_tvalid(m_tvalid),
        .m_axis_tx_tready(m_tready),
        .m_axis_tx_tlast (m_tlast),
        .m_axis_tx_tkeep (m_tkeep),
        .m_axis_tx_tdata (m_tdata),
        .m_axis_tx_tuser (m_tuser),
        .frame_tx_cnt    (tx_cnt),
        .frame_drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [95:0] got,
                         input logic [95:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        case (mode)
            0: m_tready = 1'b1;
            1: m_tready = 1'b0;
            2: m_tready = ~m_tready;
            default: m_tready = 1'($urandom_range(0, 1));
        endcase
    end

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 0;
            in_frame = 0;
        end else begin
            if (prev_stall)
                check("hold", {m_tvalid, m_tlast, m_tkeep, m_tdata},
                      {1'b1, prev});
            if (in_frame)
                check("gap", m_tvalid, 1);
            if (m_tvalid && m_tready) begin
                check("qnonempty", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    check("beat", {m_tlast, m_tkeep, m_tdata},
                          exp_q.pop_front());
                    n_pop++;
                end
                check("tuser", m_tuser, 0);
                in_frame = !m_tlast;
            end
            prev_stall = m_tvalid & !m_tready;
            prev = '{tlast: m_tlast, tkeep: m_tkeep, tdata: m_tdata};
        end
    end

    task automatic send(input int n, input logic [7:0] lk, input bit badf,
                        input bit ok);
        eth_beat_t b;
        for (int i = 0; i < n; i++) begin
            b.tdata = {$urandom, $urandom};
            b.tlast = (i == n - 1);
            b.tkeep = b.tlast ? lk : 8'hFF;
            s_tvalid = 1'b1;
            s_tdata = b.tdata;
            s_tlast = b.tlast;
            s_tkeep = b.tkeep;
            s_tuser = b.tlast & badf;
            if (ok) begin
                exp_q.push_back(b);
                n_push++;
            end
            check("srdy", s_tready, 1);
            @(posedge clk);
            #1;
        end
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
        s_tuser = 1'b0;
        if (ok) exp_tx++;
        else exp_drop++;
    endtask

    task automatic drain();
        int b = 0;
        while (exp_q.size() != 0 && b < 5000) begin
            @(posedge clk);
            b++;
        end
        check("drain", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #1;
        check("rst_vld", m_tvalid, 0);
        check("rst_out", {m_tlast, m_tkeep, m_tdata}, 0);
        check("rst_cnt", {tx_cnt, drop_cnt}, 0);
        check("rst_srdy", s_tready, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("srdy_up", s_tready, 1);
        @(posedge clk);
        #1;

        send(8, 8'hFF, 0, 1);
        @(negedge clk);
        check("lat_c1", m_tvalid, 0);
        @(negedge clk);
        check("lat_c2", m_tvalid, 1);
        drain();
        check("t1_tx", tx_cnt, exp_tx);

        send(8, 8'hFF, 1, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("novalid", m_tvalid, 0);
        end
        check("t2_drop", drop_cnt, exp_drop);
        send(3, 8'h0F, 0, 1);
        drain();
        check("t2_tx", tx_cnt, exp_tx);

        mode = 1;
        @(posedge clk);
        #1;
        send(20, 8'hFF, 0, 0);
        send(4, 8'hF0, 0, 1);
        repeat (4) @(posedge clk);
        #1;
        check("t3_drop", drop_cnt, exp_drop);
        check("t3_vld", m_tvalid, 1);
        mode = 0;
        drain();
        check("t3_tx", tx_cnt, exp_tx);

        mode = 2;
        send(6, 8'h7F, 0, 1);
        send(6, 8'h01, 0, 1);
        drain();
        check("t4_tx", tx_cnt, exp_tx);

        mode = 3;
        for (int f = 0; f < 100; f++) begin
            int w = 0;
            while (n_push - n_pop + 7 > DEP && w < 2000) begin
                @(posedge clk);
                #1;
                w++;
            end
            if (w >= 2000) check("t5_space", w, 0);
            send(7, 8'h03, 0, 1);
        end
        drain();
        check("t5_drop", drop_cnt, exp_drop);
        check("t5_tx", tx_cnt, exp_tx);

        mode = 0;
        begin
            int p0 = n_pop;
            int w = 0;
            send(10, 8'hFF, 0, 1);
            while (n_pop - p0 < 3 && w < 200) begin
                @(posedge clk);
                #1;
                w++;
            end
            check("t6_wait", n_pop - p0 >= 3, 1);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("t6_vld", m_tvalid, 0);
        check("t6_cnt", {tx_cnt, drop_cnt}, 0);
        check("t6_srdy", s_tready, 0);
        exp_q.delete();
        n_push = 0;
        n_pop = 0;
        exp_tx = 0;
        exp_drop = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        send(5, 8'h3F, 0, 1);
        drain();
        check("t6_tx", tx_cnt, exp_tx);
        check("t6_drop", drop_cnt, exp_drop);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
